// File: rtl/fft_reorder_pkg.sv
// Shared constants and read-side state encoding for the FFT reorder buffer.
package fft_reorder_pkg;

  localparam int unsigned WIDTH    = 18;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned SAMPLE_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPrime  = 2'd1,
    StStream = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fft_reorder_buffer_if.sv
// Sample streams around the reorder buffer: scrambled FFT input, natural-order output.
interface fft_reorder_buffer_if #(
  parameter int unsigned WIDTH  = fft_reorder_pkg::WIDTH,
  parameter int unsigned ADDR_W = fft_reorder_pkg::ADDR_W
);

  logic [WIDTH-1:0]  di_re;
  logic [WIDTH-1:0]  di_im;
  logic              di_en;
  logic [ADDR_W-1:0] di_addr;
  logic              di_finish;
  logic [ADDR_W-1:0] points;

  logic [WIDTH-1:0]  do_re;
  logic [WIDTH-1:0]  do_im;
  logic              do_valid;
  logic              do_ready;
  logic [ADDR_W-1:0] do_idx;
  logic              do_last;

  // Upstream FFT plus downstream mapper side.
  modport master (
    output di_re, di_im, di_en, di_addr, di_finish, points, do_ready,
    input  do_re, do_im, do_valid, do_idx, do_last
  );

  // Reorder buffer side.
  modport slave (
    input  di_re, di_im, di_en, di_addr, di_finish, points, do_ready,
    output do_re, do_im, do_valid, do_idx, do_last
  );

endinterface

// File: rtl/reorder_bank.sv
// One frame bank: simple dual-port RAM with a registered read port.
module reorder_bank #(
  parameter int unsigned DATA_W = fft_reorder_pkg::SAMPLE_W,
  parameter int unsigned ADDR_W = fft_reorder_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port; storage is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port holds its last word while re is low, so it doubles as the skid entry.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: scrambled FFT writes in, natural-order valid/ready stream out.
module fft_reorder_buffer #(
  parameter int unsigned WIDTH  = fft_reorder_pkg::WIDTH,
  parameter int unsigned ADDR_W = fft_reorder_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_reorder_buffer_if.slave  bus,
  output logic                 busy,
  output logic                 overrun,
  output logic                 len_err
);
  import fft_reorder_pkg::*;

  localparam int unsigned SW = 2 * WIDTH;

  // Shared bank state
  logic                       wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0]                 full_q, full_d;
  logic [1:0][ADDR_W-1:0]     len_q, len_d;

  // Write side
  logic [ADDR_W-1:0]          wcnt_q, wcnt_d;
  logic                       overrun_q, overrun_d, len_err_q, len_err_d;
  logic                       wr_fire, full_set, wr_first, frame_end;
  logic [ADDR_W-1:0]          cur_len;

  // Read side
  rd_state_e                  state_q, state_d;
  logic                       valid_q, valid_d, last_q, last_d, full_clr;
  logic [WIDTH-1:0]           re_q, re_d, im_q, im_d;
  logic [ADDR_W-1:0]          idx_q, idx_d, rd_addr, rd_len;
  logic                       rd_re;
  logic [SW-1:0]              rdata0, rdata1, rdata;

  reorder_bank #(.DATA_W(SW), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_fire & ~wbank_q),
    .waddr (bus.di_addr),
    .wdata ({bus.di_re, bus.di_im}),
    .re    (rd_re & ~rbank_q),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  reorder_bank #(.DATA_W(SW), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_fire & wbank_q),
    .waddr (bus.di_addr),
    .wdata ({bus.di_re, bus.di_im}),
    .re    (rd_re & rbank_q),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  assign rdata  = rbank_q ? rdata1 : rdata0;
  assign rd_len = len_q[rbank_q];

  // Write side: drop on full bank, latch length on first write, close frame on count.
  always_comb begin
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    len_d     = len_q;
    overrun_d = overrun_q;
    len_err_d = len_err_q;
    wr_fire   = 1'b0;
    full_set  = 1'b0;
    wr_first  = (wcnt_q == '0);
    cur_len   = wr_first ? bus.points : len_q[wbank_q];
    frame_end = (wcnt_q == cur_len - ADDR_W'(1));
    if (bus.di_en) begin
      if (full_q[wbank_q]) begin
        overrun_d = 1'b1;
      end else if (wr_first && (bus.points == '0)) begin
        len_err_d = 1'b1;
      end else begin
        wr_fire = 1'b1;
        if (wr_first) len_d[wbank_q] = bus.points;
        // The count, not di_finish, decides where the frame ends.
        if (bus.di_finish != frame_end) len_err_d = 1'b1;
        if (frame_end) begin
          full_set = 1'b1;
          wbank_d  = ~wbank_q;
          wcnt_d   = '0;
        end else begin
          wcnt_d = wcnt_q + ADDR_W'(1);
        end
      end
    end
  end

  // Read FSM: prime the output register, then keep the RAM one address ahead.
  always_comb begin
    state_d  = state_q;
    rbank_d  = rbank_q;
    valid_d  = valid_q;
    last_d   = last_q;
    re_d     = re_q;
    im_d     = im_q;
    idx_d    = idx_q;
    rd_re    = 1'b0;
    rd_addr  = idx_q + ADDR_W'(2);
    full_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_q[rbank_q]) begin
          rd_re   = 1'b1;
          rd_addr = '0;
          state_d = StPrime;
        end
      end
      StPrime: begin
        valid_d = 1'b1;
        re_d    = rdata[SW-1:WIDTH];
        im_d    = rdata[WIDTH-1:0];
        idx_d   = '0;
        last_d  = (rd_len - ADDR_W'(1) == '0);
        rd_re   = 1'b1;
        rd_addr = ADDR_W'(1);
        state_d = StStream;
      end
      StStream: begin
        if (valid_q && bus.do_ready) begin
          if (last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            idx_d    = '0;
            full_clr = 1'b1;
            rbank_d  = ~rbank_q;
            state_d  = StIdle;
          end else begin
            re_d    = rdata[SW-1:WIDTH];
            im_d    = rdata[WIDTH-1:0];
            idx_d   = idx_q + ADDR_W'(1);
            last_d  = (idx_q + ADDR_W'(1) == rd_len - ADDR_W'(1));
            rd_re   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Full flags: write and read sides only ever touch different banks in one cycle.
  always_comb begin
    full_d = full_q;
    if (full_set) full_d[wbank_q] = 1'b1;
    if (full_clr) full_d[rbank_q] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      full_q    <= 2'b00;
      len_q     <= '0;
      wcnt_q    <= '0;
      overrun_q <= 1'b0;
      len_err_q <= 1'b0;
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      idx_q     <= '0;
    end else begin
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      full_q    <= full_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      overrun_q <= overrun_d;
      len_err_q <= len_err_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      re_q      <= re_d;
      im_q      <= im_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.do_re    = re_q;
  assign bus.do_im    = im_q;
  assign bus.do_valid = valid_q;
  assign bus.do_idx   = idx_q;
  assign bus.do_last  = last_q;
  assign busy         = (|full_q) | (wcnt_q != '0);
  assign overrun      = overrun_q;
  assign len_err      = len_err_q;

endmodule
